// File: rtl/async_rx_pkg.sv
// Shared definitions for the oversampling async receiver: parity modes, FSM states
// and the frame-length helper.
package async_rx_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Start bit + payload + optional parity + stop bits.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/async_rx_sampler.sv
// Line synchronizer, falling-edge detect, per-bit sample counter and 3-sample
// majority voter around the bit centre.
module async_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic run,
  output logic ds,
  output logic fall_edge,
  output logic bit_val,
  output logic vote_strobe,
  output logic bit_end
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SLast = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SMid  = SW'(OVERSAMPLE / 2);

  logic          sync1_q, ds_q, ds_prev_q;
  logic          v0_q, v1_q;
  logic [SW-1:0] s_q;

  // Sync flops reset high so the idle line shows no edge when reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      ds_q      <= 1'b1;
      ds_prev_q <= 1'b1;
      s_q       <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
    end else begin
      sync1_q   <= d;
      ds_q      <= sync1_q;
      ds_prev_q <= ds_q;
      if (!run || s_q == SLast) s_q <= '0;
      else                      s_q <= s_q + 1'b1;
      if (s_q == SMid - 1'b1) v0_q <= ds_q;
      if (s_q == SMid)        v1_q <= ds_q;
    end
  end

  assign ds          = ds_q;
  assign fall_edge   = !ds_q && ds_prev_q;
  // Third sample is taken live at the vote edge.
  assign bit_val     = (v0_q & v1_q) | (v0_q & ds_q) | (v1_q & ds_q);
  assign vote_strobe = run && (s_q == SMid + 1'b1);
  assign bit_end     = run && (s_q == SLast);

endmodule

// File: rtl/async_receiver_os.sv
// Oversampling async receiver: frame FSM, payload shift register, error flags and
// Valid/Ack handshake toward the consumer.
module async_receiver_os
  import async_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 6,
  parameter int unsigned PARITY_MODE = 2,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned STOP_LEVEL  = 1,
  parameter int unsigned OVERSAMPLE  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 D,
  input  logic                 Ack,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Valid,
  output logic                 Ready,
  output logic                 ParityError,
  output logic                 FrameError,
  output logic                 Overrun
);

  localparam int unsigned FrameBits = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam int unsigned BW = $clog2(FrameBits);
  localparam logic [BW-1:0] LastData = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LastStop = BW'(STOP_BITS - 1);
  localparam logic OddPar  = (PARITY_MODE == PARITY_ODD);
  localparam logic StopLvl = STOP_LEVEL[0];

  rx_state_e            state_q;
  logic [BW-1:0]        b_q;
  logic [DATA_BITS-1:0] shreg_q, dout_q;
  logic                 par_flag_q, frm_flag_q;
  logic                 valid_q, ready_q, perr_q, ferr_q, ovr_q;
  logic                 ds, fall_edge, bit_val, vote_strobe, bit_end;

  async_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk        (Clk),
    .rst        (Rst),
    .d          (D),
    .run        (state_q != StIdle),
    .ds         (ds),
    .fall_edge  (fall_edge),
    .bit_val    (bit_val),
    .vote_strobe(vote_strobe),
    .bit_end    (bit_end)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      b_q        <= '0;
      shreg_q    <= '0;
      dout_q     <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (Ack && valid_q) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (fall_edge && !ds) begin
            state_q    <= StStart;
            ready_q    <= 1'b0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
          end
        end
        StStart: begin
          if (vote_strobe && bit_val) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else if (bit_end) begin
            state_q <= StData;
            b_q     <= '0;
          end
        end
        StData: begin
          if (vote_strobe) begin
            for (int i = 0; i < int'(DATA_BITS); i++) begin
              if (b_q == BW'(i)) shreg_q[i] <= bit_val;
            end
          end
          if (bit_end) begin
            if (b_q == LastData) begin
              b_q     <= '0;
              state_q <= (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
            end else begin
              b_q <= b_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (vote_strobe && (bit_val != (^shreg_q ^ OddPar))) par_flag_q <= 1'b1;
          if (bit_end) begin
            state_q <= StStop;
            b_q     <= '0;
          end
        end
        StStop: begin
          if (bit_end && b_q != LastStop) b_q <= b_q + 1'b1;
          if (vote_strobe) begin
            if (bit_val != StopLvl) frm_flag_q <= 1'b1;
            // Complete at the last stop-bit vote so the next start edge is not missed.
            if (b_q == LastStop) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              b_q     <= '0;
              dout_q  <= shreg_q;
              valid_q <= 1'b1;
              perr_q  <= par_flag_q;
              ferr_q  <= frm_flag_q | (bit_val != StopLvl);
              ovr_q   <= valid_q && !Ack;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Dout        = dout_q;
  assign Valid       = valid_q;
  assign Ready       = ready_q;
  assign ParityError = perr_q;
  assign FrameError  = ferr_q;
  assign Overrun     = ovr_q;

endmodule

// File: tb/tb_async_receiver_os.sv
// Scoreboard bench for async_receiver_os: a default-config instance (a) and an
// 8N2 instance (b) driven by a serial-frame generator.
module tb_async_receiver_os;

  localparam int unsigned OS = 8;

  typedef struct {
    int          dut;
    int unsigned done;
    logic        pre_low;
    logic [15:0] dout;
    logic        perr;
    logic        ferr;
    logic        ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       da, db, ack_a, ack_b;
  logic [5:0] dout_a;
  logic [7:0] dout_b;
  logic       valid_a, ready_a, perr_a, ferr_a, ovr_a;
  logic       valid_b, ready_b, perr_b, ferr_b, ovr_b;

  int unsigned cyc = 0;
  int unsigned ack_cyc = 32'hffff_ffff;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        m_valid[2] = '{1'b0, 1'b0};
  exp_t        sb[$];
  exp_t        mon_e;

  async_receiver_os u_dut_a (
    .Clk(clk), .Rst(rst), .D(da), .Ack(ack_a), .Dout(dout_a), .Valid(valid_a),
    .Ready(ready_a), .ParityError(perr_a), .FrameError(ferr_a), .Overrun(ovr_a)
  );

  async_receiver_os #(
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .STOP_LEVEL(1), .OVERSAMPLE(OS)
  ) u_dut_b (
    .Clk(clk), .Rst(rst), .D(db), .Ack(ack_b), .Dout(dout_b), .Valid(valid_b),
    .Ready(ready_b), .ParityError(perr_b), .FrameError(ferr_b), .Overrun(ovr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Pop the expected frame at the edge it must complete on, and check Valid was low
  // one edge earlier when no frame was pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].pre_low && cyc == sb[0].done - 1)
        check("valid_early", {31'b0, (sb[0].dut == 0) ? valid_a : valid_b}, 0);
      if (cyc == sb[0].done) begin
        mon_e = sb.pop_front();
        if (mon_e.dut == 0) begin
          check("valid_a", {31'b0, valid_a}, 1);
          check("dout_a", {26'b0, dout_a}, {16'b0, mon_e.dout});
          check("perr_a", {31'b0, perr_a}, {31'b0, mon_e.perr});
          check("ferr_a", {31'b0, ferr_a}, {31'b0, mon_e.ferr});
          check("ovr_a", {31'b0, ovr_a}, {31'b0, mon_e.ovr});
        end else begin
          check("valid_b", {31'b0, valid_b}, 1);
          check("dout_b", {24'b0, dout_b}, {16'b0, mon_e.dout});
          check("ferr_b", {31'b0, ferr_b}, {31'b0, mon_e.ferr});
          check("ovr_b", {31'b0, ovr_b}, {31'b0, mon_e.ovr});
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      da    = 1'b1;
      db    = 1'b1;
      ack_a = (cyc == ack_cyc);
      @(negedge clk);
    end
    ack_a = 1'b0;
  endtask

  // Drive one frame; called on a negedge. noise_bit >= 0 flips one sample of that data bit.
  task automatic send(input int dut, input logic [15:0] data, input logic par_bit,
                      input logic [1:0] stop_v, input bit ack_done, input int noise_bit);
    int          nd, ns, n;
    logic        bits[$];
    logic        line;
    exp_t        e;
    nd = (dut == 0) ? 6 : 8;
    ns = (dut == 0) ? 1 : 2;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(data[i]);
    if (dut == 0) bits.push_back(par_bit);
    for (int i = 0; i < ns; i++) bits.push_back(stop_v[i]);
    n = bits.size();
    e.dut     = dut;
    e.done    = cyc + 1 + 3 + (n - 1) * OS + OS / 2 + 1;
    e.pre_low = !m_valid[dut];
    e.dout    = (dut == 0) ? (data & 16'h003f) : (data & 16'h00ff);
    e.perr    = (dut == 0) && (par_bit != ~(^data[5:0]));
    e.ferr    = (stop_v[0] != 1'b1) || (dut == 1 && stop_v[1] != 1'b1);
    e.ovr     = m_valid[dut] && !ack_done;
    sb.push_back(e);
    m_valid[dut] = 1'b1;
    if (ack_done) ack_cyc = e.done - 1;
    for (int k = 0; k < n * int'(OS); k++) begin
      line = bits[k / OS];
      if (noise_bit >= 0 && k == (1 + noise_bit) * int'(OS) + 4) line = !line;
      if (dut == 0) da = line;
      else          db = line;
      ack_a = (cyc == ack_cyc);
      @(negedge clk);
    end
  endtask

  task automatic ack_pulse(input int dut);
    if (dut == 0) ack_a = 1'b1;
    else          ack_b = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
    m_valid[dut] = 1'b0;
    if (dut == 0) begin
      check("ack_valid_a", {31'b0, valid_a}, 0);
      check("ack_flags_a", {29'b0, perr_a, ferr_a, ovr_a}, 0);
    end else begin
      check("ack_valid_b", {31'b0, valid_b}, 0);
      check("ack_flags_b", {29'b0, perr_b, ferr_b, ovr_b}, 0);
    end
  endtask

  initial begin
    int unsigned c;
    rst = 1'b1; da = 1'b1; db = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", {26'b0, dout_a}, 0);
    check("rst_valid", {31'b0, valid_a}, 0);
    check("rst_ready", {31'b0, ready_a}, 1);
    check("rst_flags", {29'b0, perr_a, ferr_a, ovr_a}, 0);
    rst = 1'b0;
    idle(5);

    // Clean frame, then parity error, then stop-bit error.
    send(0, 16'h2d, 1'b1, 2'b11, 1'b0, -1); idle(12); ack_pulse(0);
    send(0, 16'h2d, 1'b0, 2'b11, 1'b0, -1); idle(12); ack_pulse(0);
    send(0, 16'h2d, 1'b1, 2'b10, 1'b0, -1); idle(12); ack_pulse(0);

    // 3-clock glitch: START entered, then rejected.
    c = cyc;
    da = 1'b0;
    repeat (3) @(negedge clk);
    idle(c + 5 - cyc);
    check("glitch_start", {31'b0, ready_a}, 0);
    idle(10);
    check("glitch_ready", {31'b0, ready_a}, 1);
    check("glitch_valid", {31'b0, valid_a}, 0);

    // Back-to-back without Ack, then completion coinciding with Ack.
    send(0, 16'h15, 1'b0, 2'b11, 1'b0, -1);
    send(0, 16'h2a, 1'b0, 2'b11, 1'b0, -1); idle(12);
    send(0, 16'h15, 1'b0, 2'b11, 1'b1, -1); idle(12);
    check("ackdone_valid", {31'b0, valid_a}, 1);
    ack_pulse(0);

    // One-clock noise inside the voting window of data bit 2.
    send(0, 16'h2d, 1'b1, 2'b11, 1'b0, 2); idle(12); ack_pulse(0);

    // Reset mid-DATA while a frame is still held unacknowledged.
    send(0, 16'h2a, 1'b0, 2'b11, 1'b0, -1); idle(12);
    da = 1'b0;
    repeat (3 * OS) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_dout", {26'b0, dout_a}, 0);
    check("midrst_valid", {31'b0, valid_a}, 0);
    check("midrst_ready", {31'b0, ready_a}, 1);
    check("midrst_flags", {29'b0, perr_a, ferr_a, ovr_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_valid[0] = 1'b0;
    idle(5);

    // 8N2 instance: clean byte, then a bad second stop bit.
    send(1, 16'ha5, 1'b0, 2'b11, 1'b0, -1); idle(16); ack_pulse(1);
    send(1, 16'h3c, 1'b0, 2'b01, 1'b0, -1); idle(16); ack_pulse(1);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
